// File: rtl/mux_pkg.sv
// Shared sizing helpers for the pipelined mux tree: depth from channel count
// and the padded (power-of-two) channel count.
package mux_pkg;

    // ceil(log2(n)); callers guarantee n >= 2 so the result is at least 1
    function automatic int mux_levels(input int n);
        int l;
        l = 0;
        while ((1 << l) < n) l++;
        return l;
    endfunction

    function automatic int mux_pad(input int n);
        return 1 << mux_levels(n);
    endfunction

endpackage

// File: rtl/mux2.sv
// Combinational 2:1 mux cell.
module mux2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_pipe_stage.sv
// One layer of the mux tree: IN channels reduced to IN/2 by 2:1 cells, followed
// by a register rank (data, select, valid) that holds when en is low.
module mux_pipe_stage #(
    parameter int IN = 2,
    parameter int W  = 8,
    parameter int SW = 1,
    parameter int SB = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   vld_in,
    input  logic [IN-1:0][W-1:0]   d_in,
    input  logic [SW-1:0]          sel_in,
    output logic                   vld_out,
    output logic [IN/2-1:0][W-1:0] d_out,
    output logic [SW-1:0]          sel_out
);

    localparam int OUT = IN / 2;

    logic [OUT-1:0][W-1:0] mux_y;

    for (genvar i = 0; i < OUT; i++) begin : g_pair
        mux2 #(.W(W)) u_mux (
            .d0  (d_in[2*i]),
            .d1  (d_in[2*i+1]),
            .sel (sel_in[SB]),
            .y   (mux_y[i])
        );
    end

    // Data and select only load on a real request so y stays put across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_out <= 1'b0;
            d_out   <= '0;
            sel_out <= '0;
        end else if (en) begin
            vld_out <= vld_in;
            if (vld_in) begin
                d_out   <= mux_y;
                sel_out <= sel_in;
            end
        end
    end

endmodule

// File: rtl/mux_pipe.sv
// Pipelined N:1 mux tree, one register rank per layer, with a global stall
// driven by downstream backpressure.
module mux_pipe
    import mux_pkg::*;
#(
    parameter  int N = 8,
    parameter  int W = 8,
    localparam int L = mux_levels(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] a,
    input  logic [L-1:0]   s,
    input  logic           i_valid,
    output logic           i_ready,
    output logic [W-1:0]   y,
    output logic           o_valid,
    input  logic           o_ready
);

    localparam int P = mux_pad(N);

    logic [L:0][P-1:0][W-1:0] lvl_d;
    logic [L:0][L-1:0]        lvl_s;
    logic [L:0]               vld_pipe;
    logic                     stall;

    assign stall    = o_valid && !o_ready;
    assign i_ready  = !stall;

    assign vld_pipe[0] = i_valid;
    assign lvl_s[0]    = s;

    // Channels beyond N read as zero, so out-of-range selects give y = 0.
    for (genvar k = 0; k < P; k++) begin : g_pad
        if (k < N) begin : g_ch
            assign lvl_d[0][k] = a[k*W +: W];
        end else begin : g_zero
            assign lvl_d[0][k] = '0;
        end
    end

    for (genvar j = 0; j < L; j++) begin : g_layer
        localparam int IN = P >> j;

        assign lvl_d[j+1][P-1:IN/2] = '0;

        mux_pipe_stage #(
            .IN (IN),
            .W  (W),
            .SW (L),
            .SB (j)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (!stall),
            .vld_in  (vld_pipe[j]),
            .d_in    (lvl_d[j][IN-1:0]),
            .sel_in  (lvl_s[j]),
            .vld_out (vld_pipe[j+1]),
            .d_out   (lvl_d[j+1][IN/2-1:0]),
            .sel_out (lvl_s[j+1])
        );
    end

    assign y       = lvl_d[L][0];
    assign o_valid = vld_pipe[L];

endmodule

// File: tb/tb_mux_pipe.sv
// Self-checking bench for mux_pipe: directed scenarios plus a randomized run
// scored against a queue of expected channel values.
`timescale 1ns/1ps
module tb_mux_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a;
    logic [2:0]  s;
    logic        i_valid, i_ready, o_valid, o_ready;
    logic [7:0]  y;

    logic [39:0] a5;
    logic [2:0]  s5;
    logic        iv5, irdy5, ov5, ordy5;
    logic [7:0]  y5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_pipe #(.N(8), .W(8)) dut (
        .clk(clk), .rst(rst), .a(a), .s(s), .i_valid(i_valid), .i_ready(i_ready),
        .y(y), .o_valid(o_valid), .o_ready(o_ready)
    );

    mux_pipe #(.N(5), .W(8)) dut5 (
        .clk(clk), .rst(rst), .a(a5), .s(s5), .i_valid(iv5), .i_ready(irdy5),
        .y(y5), .o_valid(ov5), .o_ready(ordy5)
    );

    // Reference: pick channel sel of an n-channel packed bus, zero if out of range.
    function automatic logic [7:0] ref_mux(input logic [63:0] av, input int sel, input int n);
        if (sel >= n) return 8'h00;
        return av[sel*8 +: 8];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 8; k++) a[k*8 +: 8] = 8'(8'h10 + k);
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; s = '0; a = '0;
        a5 = '0; s5 = '0; iv5 = 1'b0; ordy5 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid got=%b want=0", o_valid); end
        total++; if (y !== 8'h00) begin bad++; $display("FAIL reset_y got=%h want=00", y); end
        total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL reset_i_ready got=%b want=1", i_ready); end
        total++; if (ov5 !== 1'b0 || y5 !== 8'h00) begin bad++; $display("FAIL reset_n5 got=%b/%h want=0/00", ov5, y5); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        set_ramp(); s = 3'd5; i_valid = 1'b1; o_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (o_valid !== 1'(k == 3)) begin bad++; $display("FAIL single_latency k=%0d got=%b want=%b", k, o_valid, k == 3); end
            if (k == 3) begin
                total++; if (y !== 8'h15) begin bad++; $display("FAIL single_y got=%h want=15", y); end
            end
            next_cycle();
            i_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        set_ramp(); o_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            i_valid = (c < 8);
            s = 3'(c);
            @(negedge clk);
            if (c >= 3 && c <= 10) begin
                total++;
                if (o_valid !== 1'b1 || y !== 8'(8'h10 + c - 3))
                    begin bad++; $display("FAIL b2b c=%0d got=%b/%h want=1/%h", c, o_valid, y, 8'(8'h10 + c - 3)); end
            end else if (c > 10) begin
                total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%b want=0", o_valid); end
            end
            next_cycle();
        end
        i_valid = 1'b0;
    endtask

    task automatic test_stall();
        logic [2:0] sel_seq [3] = '{3'd2, 3'd4, 3'd6};
        logic [7:0] exp;
        set_ramp();
        for (int c = 0; c <= 10; c++) begin
            i_valid = (c <= 6);
            s       = (c < 3) ? sel_seq[c] : 3'd7;
            o_ready = (c >= 7);
            @(negedge clk);
            if (c < 3) begin
                total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL stall_pre_ready c=%0d got=%b want=1", c, i_ready); end
            end else if (c <= 6) begin
                total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL stall_i_ready c=%0d got=%b want=0", c, i_ready); end
                total++; if (o_valid !== 1'b1 || y !== 8'h12) begin bad++; $display("FAIL stall_hold c=%0d got=%b/%h want=1/12", c, o_valid, y); end
            end else if (c <= 9) begin
                exp = ref_mux(a, int'(sel_seq[c-7]), 8);
                total++; if (o_valid !== 1'b1 || y !== exp) begin bad++; $display("FAIL stall_release c=%0d got=%b/%h want=1/%h", c, o_valid, y, exp); end
            end else begin
                total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stall_extra got=%b want=0", o_valid); end
            end
            next_cycle();
        end
        i_valid = 1'b0;
    endtask

    task automatic test_n5();
        logic [2:0] sel_seq [4] = '{3'd6, 3'd4, 3'd7, 3'd0};
        logic [7:0] exp_seq [4] = '{8'h00, 8'h05, 8'h00, 8'h01};
        for (int k = 0; k < 5; k++) a5[k*8 +: 8] = 8'(k + 1);
        ordy5 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            iv5 = (c < 4);
            s5  = (c < 4) ? sel_seq[c] : 3'd0;
            @(negedge clk);
            if (c >= 3 && c <= 6) begin
                total++;
                if (ov5 !== 1'b1 || y5 !== exp_seq[c-3])
                    begin bad++; $display("FAIL n5 c=%0d got=%b/%h want=1/%h", c, ov5, y5, exp_seq[c-3]); end
            end
            next_cycle();
        end
        iv5 = 1'b0;
    endtask

    task automatic test_async_reset();
        set_ramp(); o_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_valid = (c < 2);
            s = (c == 0) ? 3'd1 : 3'd3;
            next_cycle();
        end
        i_valid = 1'b0;
        #1;
        total++; if (o_valid !== 1'b1 || y !== 8'h11) begin bad++; $display("FAIL areset_pre got=%b/%h want=1/11", o_valid, y); end
        #1 rst = 1'b1;
        #1;
        total++; if (o_valid !== 1'b0 || y !== 8'h00) begin bad++; $display("FAIL areset_now got=%b/%h want=0/00", o_valid, y); end
        #2 rst = 1'b0;
        o_ready = 1'b1; i_valid = 1'b1; s = 3'd6;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            i_valid = 1'b0;
            @(negedge clk);
            total++;
            if (o_valid !== 1'(k == 3)) begin bad++; $display("FAIL areset_after k=%0d got=%b want=%b", k, o_valid, k == 3); end
            if (k == 3) begin
                total++; if (y !== 8'h16) begin bad++; $display("FAIL areset_fresh_y got=%h want=16", y); end
            end
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] exp;
        for (int c = 0; c < 10006; c++) begin
            i_valid = (c < 10000) ? (($urandom % 4) != 0) : 1'b0;
            o_ready = (c < 10000) ? (($urandom % 3) != 0) : 1'b1;
            s = 3'($urandom);
            a = {$urandom, $urandom};
            @(negedge clk);
            total++;
            if (i_ready !== !(o_valid && !o_ready))
                begin bad++; $display("FAIL rand_i_ready c=%0d got=%b ov=%b ordy=%b", c, i_ready, o_valid, o_ready); end
            if (o_valid && o_ready) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL rand_spurious c=%0d got=%h want=none", c, y); end
                else begin
                    exp = q.pop_front();
                    if (y !== exp) begin bad++; $display("FAIL rand_data c=%0d got=%h want=%h", c, y, exp); end
                end
            end
            if (i_valid && i_ready) q.push_back(ref_mux(a, int'(s), 8));
            next_cycle();
        end
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL rand_lost got=%0d pending want=0", q.size()); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_n5();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 Parameter N, default 8: number of input channels, N >= 2, need not be a power of two.
REQ-002 Parameter W, default 8: bit width of each channel.
REQ-003 Derived constant L = ceil(log2(N)): tree depth, select width and pipeline latency.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 a  input  N*W  packed channels; channel k is a[k*W +: W].
REQ-007 s  input  L  channel select, sampled with a.
REQ-008 i_valid  input  1  a and s hold a request this cycle.
REQ-009 i_ready  output  1  block accepts a request this cycle.
REQ-010 y  output  W  selected channel data.
REQ-011 o_valid  output  1  y holds a result.
REQ-012 o_ready  input  1  downstream accepts y this cycle.

Function
REQ-013 The block SHALL be a binary mux tree of L layers, with one register rank after each layer.
REQ-014 Layer 1 SHALL use s[0] and layer j SHALL use s[j-1]; each select bit is carried in the pipeline alongside its data.
REQ-015 Inputs SHALL be zero-padded to 2^L channels, so that s >= N produces y = 0.
REQ-016 A request SHALL be accepted on a cycle where i_valid && i_ready.
REQ-017 Latency: an accepted request with no stall SHALL produce o_valid on exactly L rising edges later.
REQ-018 The stall condition SHALL be stall = o_valid && !o_ready.
REQ-019 While stalled, every rank (data, select, valid) SHALL hold its value, and i_ready SHALL be 0.
REQ-020 When not stalled, every rank SHALL advance by one position per cycle, and i_ready SHALL be 1.
REQ-021 i_ready SHALL depend combinationally only on o_valid and o_ready, never on i_valid.
REQ-022 A cycle with i_valid = 0 and no stall SHALL insert a bubble (valid = 0) into rank 1.
REQ-023 Bubbles are not collapsed; throughput SHALL be one result per cycle when o_ready is held at 1.
REQ-024 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-025 y and o_valid SHALL be driven directly from the last register rank, with no combinational path from a or s.
REQ-026 y SHALL hold its last value while o_valid = 0; its value is don't-care but stable.

Reset
REQ-027 While rst is high, every valid bit SHALL be 0, every data and select rank SHALL be 0, and o_valid and y SHALL be 0.
REQ-028 Reset mid-operation SHALL discard all in-flight requests without emitting them.
REQ-029 The first acceptance after reset SHALL be possible on the first rising edge with rst low.

Structure
REQ-030 The shared package mux_pkg SHALL hold the function computing L from N and the padded-count constant 2^L.
REQ-031 One sub-module, mux_pipe_stage, SHALL implement one layer: parameters IN (channels in) and W; a 2:1 mux per output pair, plus its register rank with hold enable.
REQ-032 mux_pipe SHALL instantiate L mux_pipe_stage instances with a generate loop, with IN halving per layer.
REQ-033 The existing combinational 2:1 mux cell SHALL be reused inside mux_pipe_stage.

Verification (N=8, W=8, L=3 unless noted)
REQ-034 Channels k = 8'h10+k, s = 5, single request, o_ready = 1 -> o_valid high exactly 3 cycles after acceptance with y = 8'h15.
REQ-035 Back-to-back requests s = 0..7 on consecutive cycles with o_ready = 1 -> y = 8'h10..8'h17 on 8 consecutive cycles.
REQ-036 o_ready = 0 held for 4 cycles with 3 requests in flight -> i_ready = 0 and y stable while stalled; after release, the remaining results appear in order with no loss.
REQ-037 N = 5, channels 1..5, s = 6 -> y = 0; s = 4 -> y = 5.
REQ-038 rst asserted asynchronously between clock edges with 2 requests in flight -> o_valid = 0 immediately; neither result is ever emitted; a fresh request after reset yields its correct result at latency 3.
REQ-039 Random stimulus for 10,000 cycles with random i_valid and o_ready, checked against a scoreboard queue -> every output matches the expected channel and order.
